// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU datapath stream mux: selection modes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_EXT   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational pointer-based arbiter: grants the first request at or after ptr, wrapping N-1 -> 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    // Walk offsets from farthest to nearest so the request closest to ptr is the final winner.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N:1 stream mux with fixed / round-robin / external-select arbitration and packet locking.
// Latency: 1 cycle from input acceptance to out_valid.
// Backpressure: in_ready only while the output register is empty or draining; a stalled output holds.
module stream_mux_arb
    import cpu_mux_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N),
    parameter int MODE  = MODE_RR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
);

    // Valid/last padded to the full index range so an out-of-range select reads as "not valid".
    localparam int NPAD = 1 << SEL_W;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] lock_src;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] arb_ptr;
    logic [NPAD-1:0]  valid_pad;
    logic [NPAD-1:0]  last_pad;
    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             load;
    logic             accept;
    logic             beat_last;

    assign valid_pad = NPAD'(in_valid);
    assign last_pad  = NPAD'(in_last);

    // Fixed priority is round-robin with the pointer pinned at source 0.
    assign arb_ptr = (MODE == MODE_RR) ? rr_ptr : '0;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (arb_ptr),
        .gnt_valid (arb_vld),
        .gnt_idx   (arb_idx)
    );

    // Grant source: frozen lock owner, external select, or arbiter result.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state == LOCK) begin
            gnt_vld = valid_pad[lock_src];
            gnt_idx = lock_src;
        end else if (MODE == MODE_EXT) begin
            gnt_vld = valid_pad[sel];
            gnt_idx = sel;
        end else begin
            gnt_vld = arb_vld;
            gnt_idx = arb_idx;
        end
    end

    // Reset gates acceptance so no source sees ready while rst_n is low.
    assign load      = !out_valid || out_ready;
    assign accept    = rst_n && load && gnt_vld;
    assign beat_last = last_pad[gnt_idx];

    // One-hot ready towards the granted source only.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Packet lock: enter on a non-last beat, leave on the owner's last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !beat_last) state_nxt = LOCK;
            LOCK:    if (accept && beat_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock owner captured on packet start; round-robin pointer advances only on packet completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_src <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            if (!beat_last) begin
                lock_src <= gnt_idx;
            end else begin
                rr_ptr <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Output register: refill on load, bubble when nothing is accepted, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
                out_last <= beat_last;
                out_src  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: one instance per mode driven with shared stimulus.
// Latency: checks outputs one cycle after each applied input set.
// Backpressure: out_ready is driven from the vector table and randomly.
module tb_stream_mux_arb;
    import cpu_mux_pkg::*;

    localparam int W  = 6;
    localparam int N  = 8;
    localparam int NI = 3;   // instance 0 fixed, 1 round-robin, 2 external select

    typedef struct {
        logic       rst;
        logic [7:0] v;
        logic [7:0] l;
        logic [5:0] d;
        logic [2:0] s;
        logic       ordy;
        int         inst;
        logic [7:0] e_rdy;
        logic       e_ov;
        logic [5:0] e_od;
        logic [2:0] e_os;
        logic       e_ol;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [2:0]     sel;
    logic           out_ready;

    logic [N-1:0]   rdy_a [NI];
    logic [W-1:0]   od_a  [NI];
    logic           ov_a  [NI];
    logic           ol_a  [NI];
    logic [2:0]     os_a  [NI];

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    // Reference model: packet owner (-1 when none), RR pointer and the output register contents.
    int         m_owner [NI];
    int         m_ptr   [NI];
    logic       m_ov    [NI];
    logic [5:0] m_od    [NI];
    int         m_os    [NI];
    logic       m_ol    [NI];
    logic [7:0] rdy_seen[NI];

    always #5 clk = ~clk;

    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(MODE_FIXED)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a[0]), .sel(sel), .out_data(od_a[0]), .out_valid(ov_a[0]),
        .out_last(ol_a[0]), .out_src(os_a[0]), .out_ready(out_ready)
    );

    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a[1]), .sel(sel), .out_data(od_a[1]), .out_valid(ov_a[1]),
        .out_last(ol_a[1]), .out_src(os_a[1]), .out_ready(out_ready)
    );

    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(MODE_EXT)) u_ext (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a[2]), .sel(sel), .out_data(od_a[2]), .out_valid(ov_a[2]),
        .out_last(ol_a[2]), .out_src(os_a[2]), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] mkdat(input logic [5:0] d);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = d ^ 6'(k);
        return r;
    endfunction

    // Which source the spec's rules would serve this cycle, or -1.
    function automatic int pick(input int inst, input logic [7:0] v, input logic [2:0] s);
        int o;
        int k;
        o = m_owner[inst];
        if (o >= 0) return v[o[2:0]] ? o : -1;
        if (inst == 2) return v[s] ? int'(s) : -1;
        for (int off = 0; off < N; off++) begin
            k = (inst == 1) ? (m_ptr[inst] + off) % N : off;
            if (v[k[2:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_owner[i] = -1;
        m_ptr[i]   = 0;
        m_ov[i]    = 1'b0;
        m_od[i]    = '0;
        m_os[i]    = 0;
        m_ol[i]    = 1'b0;
    endtask

    // Applies one cycle of stimulus (called at posedge+1) and checks every instance against the model.
    task automatic run_cycle(input logic rst, input logic [7:0] v, input logic [7:0] l,
                             input logic [47:0] dat, input logic [2:0] s, input logic ordy);
        int   g [NI];
        logic ld[NI];
        int   gi;
        rst_n = ~rst; in_valid = v; in_last = l; in_data = dat; sel = s; out_ready = ordy;
        #3;
        for (int i = 0; i < NI; i++) begin
            ld[i] = ~m_ov[i] | ordy;
            g[i]  = (rst || !ld[i]) ? -1 : pick(i, v, s);
            rdy_seen[i] = rdy_a[i];
            chk($sformatf("model in_ready inst%0d", i), rdy_a[i], (g[i] >= 0) ? (8'h1 << g[i]) : 8'h0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                model_reset(i);
            end else if (ld[i]) begin
                if (g[i] >= 0) begin
                    gi       = g[i];
                    m_ov[i]  = 1'b1;
                    m_od[i]  = dat[gi*W +: W];
                    m_ol[i]  = l[gi[2:0]];
                    m_os[i]  = gi;
                    if (l[gi[2:0]]) begin
                        m_owner[i] = -1;
                        m_ptr[i]   = (gi + 1) % N;
                    end else begin
                        m_owner[i] = gi;
                    end
                end else begin
                    m_ov[i] = 1'b0;
                end
            end
            chk($sformatf("model out_valid inst%0d", i), ov_a[i], m_ov[i]);
            chk($sformatf("model out_data inst%0d", i),  od_a[i], m_od[i]);
            chk($sformatf("model out_src inst%0d", i),   os_a[i], m_os[i]);
            chk($sformatf("model out_last inst%0d", i),  ol_a[i], m_ol[i]);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] v, input logic [7:0] l, input logic [5:0] d,
                       input logic [2:0] s, input logic ordy, input int inst, input logic [7:0] e_rdy,
                       input logic e_ov, input logic [5:0] e_od, input logic [2:0] e_os, input logic e_ol);
        vec_t x;
        x.rst = rst; x.v = v; x.l = l; x.d = d; x.s = s; x.ordy = ordy; x.inst = inst;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_od = e_od; x.e_os = e_os; x.e_ol = e_ol;
        tbl.push_back(x);
    endtask

    initial begin
        int ti;
        for (int i = 0; i < NI; i++) model_reset(i);

        // Source k carries d ^ k, so expected data is d ^ out_src.
        //   rst  valid  last   d      sel   ordy inst  e_rdy  ov  od     os    ol
        // Reset with all sources valid, then a single beat from source 2.
        add(1, 8'hFF, 8'hFF, 6'h00, 3'd0, 1, 1, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'h04, 8'h04, 6'h28, 3'd0, 1, 1, 8'h04, 1, 6'h2A, 3'd2, 1);
        // Round-robin fairness from a fresh pointer: 0..7 then 0.
        add(1, 8'h00, 8'h00, 6'h00, 3'd0, 1, 1, 8'h00, 0, 6'h00, 3'd0, 0);
        for (int k = 0; k < 9; k++)
            add(0, 8'hFF, 8'hFF, 6'h00, 3'd0, 1, 1, 8'h01 << (k % 8), 1, 6'(k % 8), 3'(k % 8), 1);
        // Packet lock: move pointer to 5, then source 5 sends 3 beats (with one bubble) while 1 waits.
        add(1, 8'h00, 8'h00, 6'h00, 3'd0, 1, 1, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'h10, 8'h10, 6'h00, 3'd0, 1, 1, 8'h10, 1, 6'h04, 3'd4, 1);
        add(0, 8'h22, 8'h00, 6'h10, 3'd0, 1, 1, 8'h20, 1, 6'h15, 3'd5, 0);
        add(0, 8'h22, 8'h00, 6'h20, 3'd0, 1, 1, 8'h20, 1, 6'h25, 3'd5, 0);
        add(0, 8'h02, 8'h02, 6'h3F, 3'd0, 1, 1, 8'h00, 0, 6'h25, 3'd5, 0);
        add(0, 8'h22, 8'h20, 6'h30, 3'd0, 1, 1, 8'h20, 1, 6'h35, 3'd5, 1);
        add(0, 8'h22, 8'h02, 6'h00, 3'd0, 1, 1, 8'h02, 1, 6'h01, 3'd1, 1);
        // Backpressure: four stalled cycles hold the beat from source 1, then source 2 follows.
        for (int k = 0; k < 4; k++)
            add(0, 8'h04, 8'h04, 6'(8 + k), 3'd0, 0, 1, 8'h00, 1, 6'h01, 3'd1, 1);
        add(0, 8'h04, 8'h04, 6'h08, 3'd0, 1, 1, 8'h04, 1, 6'h0A, 3'd2, 1);
        // External select: invalid selected source, then a locked packet ignores sel changes.
        add(1, 8'h00, 8'h00, 6'h00, 3'd0, 1, 2, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'hF7, 8'h00, 6'h00, 3'd3, 1, 2, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'h08, 8'h00, 6'h10, 3'd3, 1, 2, 8'h08, 1, 6'h13, 3'd3, 0);
        add(0, 8'h48, 8'h00, 6'h20, 3'd6, 1, 2, 8'h08, 1, 6'h23, 3'd3, 0);
        add(0, 8'h48, 8'h08, 6'h30, 3'd6, 1, 2, 8'h08, 1, 6'h33, 3'd3, 1);
        add(0, 8'h48, 8'h40, 6'h00, 3'd6, 1, 2, 8'h40, 1, 6'h06, 3'd6, 1);
        // Reset during beat 2 of a source-4 packet; fixed priority then prefers source 0.
        add(1, 8'h00, 8'h00, 6'h00, 3'd0, 1, 0, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'h10, 8'h00, 6'h00, 3'd0, 1, 0, 8'h10, 1, 6'h04, 3'd4, 0);
        add(1, 8'h10, 8'h00, 6'h00, 3'd0, 1, 0, 8'h00, 0, 6'h00, 3'd0, 0);
        add(0, 8'h11, 8'h11, 6'h08, 3'd0, 1, 0, 8'h01, 1, 6'h08, 3'd0, 1);

        foreach (tbl[r]) begin
            run_cycle(tbl[r].rst, tbl[r].v, tbl[r].l, mkdat(tbl[r].d), tbl[r].s, tbl[r].ordy);
            ti = tbl[r].inst;
            chk($sformatf("row%0d in_ready", r),  rdy_seen[ti], tbl[r].e_rdy);
            chk($sformatf("row%0d out_valid", r), ov_a[ti],     tbl[r].e_ov);
            chk($sformatf("row%0d out_data", r),  od_a[ti],     tbl[r].e_od);
            chk($sformatf("row%0d out_src", r),   os_a[ti],     tbl[r].e_os);
            chk($sformatf("row%0d out_last", r),  ol_a[ti],     tbl[r].e_ol);
        end

        // Randomised traffic with occasional resets, checked against the model only.
        for (int c = 0; c < 600; c++) begin
            run_cycle(($urandom_range(0, 99) == 0), 8'($urandom), 8'($urandom),
                      {16'($urandom), 32'($urandom)}, 3'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-to-1 registered stream multiplexer with built-in arbitration and packet locking for the 6-bit CPU datapath. It generalises the plain combinational 8:1 6-bit selector in three ways:
- any width and input count;
- valid/ready handshake per source;
- three selection modes (fixed priority, round-robin, external select).

It sits between multiple 6-bit producers (ALU, register-file read ports, immediate path, I/O) and a single consumer bus, holding a grant for the duration of a multi-beat packet.

## Interface
Parameters:
- `WIDTH`, default 6: data width per source.
- `N`, default 8: number of sources, 2..16.
- `SEL_W`, default `$clog2(N)` (3 at default): width of source index.
- `MODE`, default `MODE_RR`: selection mode; one of `MODE_FIXED`, `MODE_RR` or `MODE_EXT`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  N*WIDTH  flattened source data; source k at `[k*WIDTH +: WIDTH]`.
- `in_valid`  in  N  per-source valid.
- `in_last`  in  N  per-source end-of-packet marker, qualified by valid.
- `in_ready`  out  N  per-source ready; at most one bit high.
- `sel`  in  SEL_W  external source select; used only when `MODE==MODE_EXT`.
- `out_data`  out  WIDTH  registered output data.
- `out_valid`  out  1  registered output valid.
- `out_last`  out  1  registered end-of-packet.
- `out_src`  out  SEL_W  index of the source that produced `out_data`.
- `out_ready`  in  1  consumer ready.

## Operation
- A beat transfers on an input when `in_valid[k] & in_ready[k]`. It transfers on the output when `out_valid & out_ready`.
- Load enable: `load = !out_valid | out_ready`. `in_ready[g] = load & (grant valid) & (k==g)`; all other bits are 0.
- State machine (2 states):
  - `IDLE`: no packet in progress; an arbitration decision is made each cycle.
  - `LOCK`: grant frozen to `lock_src`; no arbitration.
  - `IDLE -> LOCK`: on an accepted beat with `in_last=0`; `lock_src` takes the granted index.
  - `LOCK -> IDLE`: on an accepted beat from `lock_src` with `in_last=1`.
  - An accepted beat with `in_last=1` while in `IDLE` stays in `IDLE` (single-beat packet).
- Arbitration in `IDLE`:
  - `MODE_FIXED`: lowest valid index wins.
  - `MODE_RR`: first valid index at or after pointer `rr_ptr`, searching upward with wrap-around from N-1 to 0. `rr_ptr` updates to `(g+1) mod N` only on packet completion (accepted `last` beat). It does not update on every beat.
  - `MODE_EXT`: grant is `sel` if `in_valid[sel]`, otherwise no grant. `sel` is sampled only in `IDLE`; changes to `sel` during `LOCK` are ignored. If `sel >= N`, there is no grant.
- Grant in `LOCK` is `lock_src`. If `in_valid[lock_src]=0`, the output bubbles and no other source is served.
- Output register:
  - On `load` with an accepted input: `out_data`, `out_last` and `out_src` capture the granted source, and `out_valid=1`.
  - On `load` with no accepted input: `out_valid=0`, and the data registers hold their values.
  - While `out_valid & !out_ready`, all outputs are stable.
- Reset values, asynchronous on `rst_n=0`:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - State `IDLE`, `rr_ptr=0`, `lock_src=0`.
  - `in_ready` is all-0 while reset is asserted.
- Reset mid-packet drops the lock and the held beat. Arbitration restarts from index 0.

## Timing
- Latency: an input beat accepted at edge t appears with `out_valid=1` after edge t, i.e. 1 cycle.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `in_ready` is combinational from `in_valid`, `out_ready`, state and `sel`. Sources must not derive `in_valid` from `in_ready`.
- No combinational path from any input to `out_*`.
- Simultaneous events in the same cycle:
  - output drain plus new load → new beat replaces the old one, with no bubble.
  - `last` acceptance plus another source valid → the new arbitration takes effect the next cycle. There is one `IDLE` decision cycle but no bubble, because arbitration happens the same cycle the state is `IDLE`.

## Structure
- Shared package `cpu_mux_pkg` holds:
  - mode constants `MODE_FIXED=0`, `MODE_RR=1`, `MODE_EXT=2`;
  - the state enum `{IDLE, LOCK}`.
- Sub-module `rr_arbiter`:
  - parameters N and SEL_W;
  - inputs: request vector, pointer;
  - outputs: `gnt_valid`, `gnt_idx`;
  - purely combinational.
  - `MODE_FIXED` reuses it with pointer tied to 0.
- Top-level contents: state register, `lock_src`, `rr_ptr`, the output register, and the mode mux.

## Test plan
- Reset and single beat:
  - Reset asserted with `in_valid=8'hFF` → `in_ready=0`, `out_valid=0`, `out_data=0`.
  - Release reset; source 2 sends `6'h2A` with `last=1` and `out_ready=1` → next cycle `out_data=6'h2A`, `out_src=2`.
- Round-robin fairness (`MODE_RR`): all 8 sources valid, single-beat packets, `out_ready=1` → `out_src` sequence 0,1,…,7,0. Each source is served once per 8 cycles.
- Packet lock: source 5 sends a 3-beat packet (`last` on beat 3) while source 1 is valid → three consecutive outputs with `out_src=5`, then `out_src=1`. `in_ready[1]=0` throughout the lock.
- Backpressure: hold `out_ready=0` for 4 cycles with `out_valid=1` → `out_data`, `out_src` and `out_last` are stable and `in_ready=0`. Release → transfer resumes with no lost or duplicated beat.
- External select (`MODE_EXT`): `sel=3` with `in_valid[3]=0` → no grant. Then `sel=6` mid-packet from source 3 → grant stays 3 until `last`.
- Reset mid-packet: assert `rst_n=0` during beat 2 of a source-4 packet → state returns to `IDLE` and `out_valid=0`. After release, a fixed-priority request from sources 0 and 4 grants source 0.
